// File: rtl/boundary_cell_param.sv
// ============================================================================
//  Module      : boundary_cell_param
//  Description : Boundary ghost-cell for the grid edge of the physics
//                accelerator. Holds one cell value plus a DEPTH-stage history
//                and advances it on each simulation tick according to a
//                run-time boundary mode (Dirichlet, Neumann, periodic,
//                absorbing decay).
//  Revision    : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   1      system clock, rising edge
//    Reset      in   1      asynchronous active-high reset
//    Tick       in   1      simulation step enable (one Clk wide)
//    Init       in   1      load INIT_VAL into every history stage
//    Mode       in   2      00 Dirichlet, 01 Neumann, 10 periodic, 11 absorbing
//    INIT_VAL   in   WIDTH  initial / fixed boundary value
//    NEXT_VAL   in   WIDTH  adjacent interior cell (Neumann source)
//    WRAP_VAL   in   WIDTH  opposite-edge cell (periodic source)
//    GC_VAL     out  WIDTH  current ghost-cell value (stage 0)
//    GC_PREV    out  WIDTH  oldest history stage (stage DEPTH-1)
//    Valid      out  1      cell has been initialised
//    StepCount  out  CNT_W  ticks applied since the last Init (wrapping)
// ============================================================================
`default_nettype none

module boundary_cell_param #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 2,
  parameter int DECAY_SHIFT = 2,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             Init,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] INIT_VAL,
  input  logic [WIDTH-1:0] NEXT_VAL,
  input  logic [WIDTH-1:0] WRAP_VAL,
  output logic [WIDTH-1:0] GC_VAL,
  output logic [WIDTH-1:0] GC_PREV,
  output logic             Valid,
  output logic [CNT_W-1:0] StepCount
);

  localparam logic [1:0] MODE_DIRICHLET = 2'b00;
  localparam logic [1:0] MODE_NEUMANN   = 2'b01;
  localparam logic [1:0] MODE_PERIODIC  = 2'b10;
  localparam logic [1:0] MODE_ABSORB    = 2'b11;

  typedef enum logic [0:0] {
    ST_UNINIT = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] shifted_d;
  logic [WIDTH-1:0] decay_d;
  logic [WIDTH-1:0] new_val_d;

  // Absorbing decay: subtract h0 >> DECAY_SHIFT, but never less than 1 while
  // h0 is non-zero, so the value is guaranteed to reach 0 and then stick.
  // decay_d <= h0 always holds, so the subtraction cannot underflow.
  always_comb begin
    shifted_d = hist_q[0] >> DECAY_SHIFT;
    decay_d   = shifted_d;
    if ((shifted_d == '0) && (hist_q[0] != '0)) begin
      decay_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end

    new_val_d = hist_q[0];
    case (Mode)
      MODE_DIRICHLET: new_val_d = INIT_VAL;
      MODE_NEUMANN:   new_val_d = NEXT_VAL;
      MODE_PERIODIC:  new_val_d = WRAP_VAL;
      MODE_ABSORB:    new_val_d = hist_q[0] - decay_d;
      default:        new_val_d = hist_q[0];
    endcase
  end

  // Single state machine: Reset > Init > Tick. A Tick coinciding with Init is
  // dropped, and Ticks before the first Init are ignored.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_UNINIT;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else if (Init) begin
      state_q <= ST_RUN;
      valid_q <= 1'b1;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= INIT_VAL;
      end
    end else if (Tick && (state_q == ST_RUN)) begin
      cnt_q     <= cnt_q + 1'b1;
      hist_q[0] <= new_val_d;
      for (int k = 1; k < DEPTH; k++) begin
        hist_q[k] <= hist_q[k-1];
      end
    end
  end

  assign GC_VAL    = hist_q[0];
  assign GC_PREV   = hist_q[DEPTH-1];
  assign Valid     = valid_q;
  assign StepCount = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_boundary_cell_param.sv
`default_nettype none

module tb_boundary_cell_param;

  logic       Clk;
  logic       Reset;
  logic       Tick;
  logic       Init;
  logic [1:0] Mode;
  logic [7:0] INIT_VAL;
  logic [7:0] NEXT_VAL;
  logic [7:0] WRAP_VAL;

  // Default instance: WIDTH=8, DEPTH=2, DECAY_SHIFT=2, CNT_W=16
  logic [7:0]  gc_a, prev_a;
  logic        valid_a;
  logic [15:0] cnt_a;

  // Corner instance: DEPTH=3, DECAY_SHIFT=0, CNT_W=4
  logic [7:0]  gc_b, prev_b;
  logic        valid_b;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  boundary_cell_param dut_a (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Init(Init), .Mode(Mode),
    .INIT_VAL(INIT_VAL), .NEXT_VAL(NEXT_VAL), .WRAP_VAL(WRAP_VAL),
    .GC_VAL(gc_a), .GC_PREV(prev_a), .Valid(valid_a), .StepCount(cnt_a)
  );

  boundary_cell_param #(.WIDTH(8), .DEPTH(3), .DECAY_SHIFT(0), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Init(Init), .Mode(Mode),
    .INIT_VAL(INIT_VAL), .NEXT_VAL(NEXT_VAL), .WRAP_VAL(WRAP_VAL),
    .GC_VAL(gc_b), .GC_PREV(prev_b), .Valid(valid_b), .StepCount(cnt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge and settle 1ns after it; inputs are changed right after.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_init(input logic [7:0] v);
    Init = 1'b1; INIT_VAL = v;
    cyc();
    Init = 1'b0;
  endtask

  task automatic do_tick();
    Tick = 1'b1;
    cyc();
    Tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cyc();
    #2 Reset = 1'b0;
    cyc();
    n_cmp++; if (gc_a !== 8'h00)   begin n_bad++; $display("FAIL reset_gc got %h exp 00", gc_a); end
    n_cmp++; if (prev_a !== 8'h00) begin n_bad++; $display("FAIL reset_prev got %h exp 00", prev_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    n_cmp++; if (cnt_a !== 16'd0)  begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
    Mode = 2'b01; NEXT_VAL = 8'h55;
    do_tick();
    n_cmp++; if (gc_a !== 8'h00)   begin n_bad++; $display("FAIL uninit_tick_gc got %h exp 00", gc_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL uninit_tick_valid got %b exp 0", valid_a); end
    n_cmp++; if (cnt_a !== 16'd0)  begin n_bad++; $display("FAIL uninit_tick_cnt got %0d exp 0", cnt_a); end
    n_cmp++; if (valid_b !== 1'b0) begin n_bad++; $display("FAIL uninit_tick_valid_b got %b exp 0", valid_b); end
  endtask

  task automatic test_neumann();
    do_init(8'h40);
    n_cmp++; if (gc_a !== 8'h40)   begin n_bad++; $display("FAIL init_gc got %h exp 40", gc_a); end
    n_cmp++; if (prev_a !== 8'h40) begin n_bad++; $display("FAIL init_prev got %h exp 40", prev_a); end
    n_cmp++; if (valid_a !== 1'b1) begin n_bad++; $display("FAIL init_valid got %b exp 1", valid_a); end
    n_cmp++; if (prev_b !== 8'h40) begin n_bad++; $display("FAIL init_prev_b got %h exp 40", prev_b); end
    Mode = 2'b01; NEXT_VAL = 8'h12;
    do_tick();
    n_cmp++; if (gc_a !== 8'h12)   begin n_bad++; $display("FAIL neu1_gc got %h exp 12", gc_a); end
    n_cmp++; if (prev_a !== 8'h40) begin n_bad++; $display("FAIL neu1_prev got %h exp 40", prev_a); end
    n_cmp++; if (cnt_a !== 16'd1)  begin n_bad++; $display("FAIL neu1_cnt got %0d exp 1", cnt_a); end
    NEXT_VAL = 8'h34;
    do_tick();
    n_cmp++; if (gc_a !== 8'h34)   begin n_bad++; $display("FAIL neu2_gc got %h exp 34", gc_a); end
    n_cmp++; if (prev_a !== 8'h12) begin n_bad++; $display("FAIL neu2_prev got %h exp 12", prev_a); end
    n_cmp++; if (cnt_a !== 16'd2)  begin n_bad++; $display("FAIL neu2_cnt got %0d exp 2", cnt_a); end
    n_cmp++; if (prev_b !== 8'h40) begin n_bad++; $display("FAIL neu2_prev_b got %h exp 40", prev_b); end
    NEXT_VAL = 8'h56;
    do_tick();
    n_cmp++; if (prev_b !== 8'h12) begin n_bad++; $display("FAIL neu3_prev_b got %h exp 12", prev_b); end
    // Idle cycles with changed inputs must hold all state
    NEXT_VAL = 8'h99; Mode = 2'b10;
    cyc(); cyc();
    n_cmp++; if (gc_a !== 8'h56)   begin n_bad++; $display("FAIL hold_gc got %h exp 56", gc_a); end
    n_cmp++; if (cnt_a !== 16'd3)  begin n_bad++; $display("FAIL hold_cnt got %0d exp 3", cnt_a); end
  endtask

  task automatic test_absorb();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h60; exp_seq[1] = 8'h48; exp_seq[2] = 8'h36; exp_seq[3] = 8'h29;
    Mode = 2'b11;
    do_init(8'h80);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      n_cmp++;
      if (gc_a !== exp_seq[i]) begin
        n_bad++; $display("FAIL absorb_step%0d got %h exp %h", i, gc_a, exp_seq[i]);
      end
      if (i == 0) begin
        n_cmp++; if (gc_b !== 8'h00) begin n_bad++; $display("FAIL absorb_shift0 got %h exp 00", gc_b); end
      end
    end
    do_init(8'h01);
    do_tick();
    n_cmp++; if (gc_a !== 8'h00) begin n_bad++; $display("FAIL absorb_one got %h exp 00", gc_a); end
    do_tick(); do_tick();
    n_cmp++; if (gc_a !== 8'h00) begin n_bad++; $display("FAIL absorb_floor got %h exp 00", gc_a); end
    n_cmp++; if (cnt_a !== 16'd3) begin n_bad++; $display("FAIL absorb_cnt got %0d exp 3", cnt_a); end
  endtask

  task automatic test_back_to_back();
    Mode = 2'b10; WRAP_VAL = 8'hAA;
    Init = 1'b1; Tick = 1'b1; INIT_VAL = 8'h07;
    cyc();
    Init = 1'b0; Tick = 1'b0;
    n_cmp++; if (gc_a !== 8'h07)  begin n_bad++; $display("FAIL init_tick_gc got %h exp 07", gc_a); end
    n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL init_tick_cnt got %0d exp 0", cnt_a); end
    do_tick();
    n_cmp++; if (gc_a !== 8'hAA)  begin n_bad++; $display("FAIL periodic_gc got %h exp aa", gc_a); end
    n_cmp++; if (prev_a !== 8'h07) begin n_bad++; $display("FAIL periodic_prev got %h exp 07", prev_a); end
    n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL periodic_cnt got %0d exp 1", cnt_a); end
  endtask

  task automatic test_dirichlet_reset();
    Mode = 2'b00;
    do_init(8'h10);
    INIT_VAL = 8'h20;
    do_tick();
    n_cmp++; if (gc_a !== 8'h20)  begin n_bad++; $display("FAIL dirichlet_gc got %h exp 20", gc_a); end
    n_cmp++; if (prev_a !== 8'h10) begin n_bad++; $display("FAIL dirichlet_prev got %h exp 10", prev_a); end
    // Async reset placed between edges; check before any edge occurs
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if (gc_a !== 8'h00)   begin n_bad++; $display("FAIL async_rst_gc got %h exp 00", gc_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid got %b exp 0", valid_a); end
    n_cmp++; if (cnt_a !== 16'd0)  begin n_bad++; $display("FAIL async_rst_cnt got %0d exp 0", cnt_a); end
    #1 Reset = 1'b0;
    cyc();
  endtask

  task automatic test_counter_wrap();
    Mode = 2'b01; NEXT_VAL = 8'h3C;
    do_init(8'h01);
    for (int i = 0; i < 17; i++) do_tick();
    n_cmp++; if (cnt_b !== 4'd1)   begin n_bad++; $display("FAIL wrap_cnt4 got %0d exp 1", cnt_b); end
    n_cmp++; if (cnt_a !== 16'd17) begin n_bad++; $display("FAIL cnt16 got %0d exp 17", cnt_a); end
    n_cmp++; if (gc_b !== 8'h3C)   begin n_bad++; $display("FAIL wrap_gc_b got %h exp 3c", gc_b); end
  endtask

  initial begin
    Reset = 1'b1; Tick = 1'b0; Init = 1'b0; Mode = 2'b00;
    INIT_VAL = 8'h00; NEXT_VAL = 8'h00; WRAP_VAL = 8'h00;
    test_reset();
    test_neumann();
    test_absorb();
    test_back_to_back();
    test_dirichlet_reset();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
